// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit for the EX stage.
// Holds the HI/LO architectural registers. mult/multu/div/divu run for a fixed
// number of cycles with busy asserted. mthi/mtlo write in a single cycle.
// HI/LO are read combinationally by mfhi/mflo.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mduOp,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;

  logic               w_is_md;
  logic               w_is_div;
  logic               w_b_zero;
  logic [31:0]        w_b_safe;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_quot_s;
  logic [31:0]        w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;

  assign w_is_md  = (mduOp == OP_MULT) || (mduOp == OP_MULTU) ||
                    (mduOp == OP_DIV)  || (mduOp == OP_DIVU);
  assign w_is_div = (mduOp == OP_DIV)  || (mduOp == OP_DIVU);

  // Divisor of zero leaves HI/LO untouched; the substitute 1 only keeps the
  // dividers free of undefined values and is never committed.
  assign w_b_zero = (r_b == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : r_b;

  // Result datapath works on the operands captured at start.
  assign w_prod_s = 64'($signed(r_a)) * 64'($signed(r_b));
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
  assign w_quot_s = $signed(r_a) / $signed(w_b_safe);
  assign w_rem_s  = $signed(r_a) % $signed(w_b_safe);
  assign w_quot_u = r_a / w_b_safe;
  assign w_rem_u  = r_a % w_b_safe;

  // Control FSM: operand capture, cycle countdown, HI/LO commit and mt writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A flushed E-stage instruction (req) must leave no trace.
          if (!req) begin
            if (start && w_is_md) begin
              r_a     <= a;
              r_b     <= b;
              r_op    <= mduOp;
              r_cnt   <= w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else if (!start && (mduOp == OP_MTHI)) begin
              r_hi <= a;
            end else if (!start && (mduOp == OP_MTLO)) begin
              r_lo <= a;
            end
          end
        end
        S_RUN: begin
          // Once issued, the operation always commits; req and new requests
          // are ignored until it finishes.
          if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            case (r_op)
              OP_MULT: begin
                r_hi <= w_prod_s[63:32];
                r_lo <= w_prod_s[31:0];
              end
              OP_MULTU: begin
                r_hi <= w_prod_u[63:32];
                r_lo <= w_prod_u[31:0];
              end
              OP_DIV: begin
                if (!w_b_zero) begin
                  r_hi <= w_rem_s;
                  r_lo <= w_quot_s;
                end
              end
              OP_DIVU: begin
                if (!w_b_zero) begin
                  r_hi <= w_rem_u;
                  r_lo <= w_quot_u;
                end
              end
              default: begin
              end
            endcase
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes the expected HI/LO and busy
// length; a negedge monitor pops and compares on every busy fall or check pulse.
module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mduOp;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;   // expected busy-high cycles, -1 = not checked
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic chk         = 1'b0;
  logic prev_busy   = 1'b0;
  int   busy_cyc    = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mduOp (mduOp),
    .a     (a),
    .b     (b),
    .req   (req),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares whenever an operation ends (busy falls) or a check is requested.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cyc = busy_cyc + 1;
    if ((prev_busy && !busy) || chk) begin
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_output: hi=%h lo=%h busy=%b, no entry expected", hi, lo, busy);
        miscompares = miscompares + 1;
      end else begin
        e = sb_q.pop_front();
        vectors = vectors + 1;
        if (hi !== e.hi || lo !== e.lo || busy !== 1'b0 ||
            (e.cycles >= 0 && busy_cyc != e.cycles)) begin
          $display("FAIL %s: got hi=%h lo=%h busy=%b cycles=%0d, want hi=%h lo=%h busy=0 cycles=%0d",
                   e.name, hi, lo, busy, busy_cyc, e.hi, e.lo, e.cycles);
          miscompares = miscompares + 1;
        end else begin
          $display("ok %s: hi=%h lo=%h cycles=%0d", e.name, hi, lo, busy_cyc);
        end
      end
      busy_cyc = 0;
    end
    prev_busy = busy;
  end

  task automatic expect_res(input string name, input logic [31:0] eh,
                            input logic [31:0] el, input int cyc);
    exp_t e;
    e.name = name; e.hi = eh; e.lo = el; e.cycles = cyc;
    sb_q.push_back(e);
  endtask

  // Present one instruction for a single E cycle, then return to nop.
  task automatic issue(input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic st, input logic rq);
    @(posedge clk); #1;
    mduOp = op; a = va; b = vb; start = st; req = rq;
    @(posedge clk); #1;
    mduOp = 4'd0; start = 1'b0; req = 1'b0; a = 32'd0; b = 32'd0;
  endtask

  // Wait (bounded) until every pushed expectation has been consumed.
  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      $display("FAIL timeout: %0d expected results never observed", sb_q.size());
      miscompares = miscompares + 1;
      sb_q.delete();
    end
  endtask

  // Request an immediate comparison of the current HI/LO and busy.
  task automatic check_now(input string name, input logic [31:0] eh, input logic [31:0] el);
    expect_res(name, eh, el, 0);
    @(posedge clk); #1;
    chk = 1'b1;
    @(posedge clk); #1;
    chk = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mduOp = 4'd0; a = 32'd0; b = 32'd0; req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    check_now("reset_state", 32'h0, 32'h0);

    // mult -3 * 7 = -21
    expect_res("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
    issue(4'd1, 32'hFFFFFFFD, 32'd7, 1'b1, 1'b0);
    drain();

    // multu 0xFFFFFFFF * 2; issue() zeroes a/b after start, so capture is exercised
    expect_res("multu_big", 32'h00000001, 32'hFFFFFFFE, 5);
    issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    drain();

    // div -7 / 2 = -3 rem -1
    expect_res("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    drain();

    // divu by zero: full latency, HI/LO unchanged
    expect_res("divu_by0", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(4'd4, 32'd7, 32'd0, 1'b1, 1'b0);
    drain();

    // divu 100 / 7 = 14 rem 2
    expect_res("divu_100_7", 32'd2, 32'd14, 10);
    issue(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
    drain();

    // div 7 / -2 = -3 rem 1 (remainder takes dividend sign)
    expect_res("div_rem_sign", 32'd1, 32'hFFFFFFFD, 10);
    issue(4'd3, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
    drain();

    // mthi then mtlo
    issue(4'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
    check_now("mthi", 32'h1234, 32'hFFFFFFFD);
    issue(4'd6, 32'h5678, 32'd0, 1'b0, 1'b0);
    check_now("mtlo", 32'h1234, 32'h5678);

    // squashed mt and start
    issue(4'd5, 32'hDEAD, 32'd0, 1'b0, 1'b1);
    check_now("mthi_req", 32'h1234, 32'h5678);
    issue(4'd6, 32'hBEEF, 32'd0, 1'b0, 1'b1);
    check_now("mtlo_req", 32'h1234, 32'h5678);
    issue(4'd1, 32'd2, 32'd3, 1'b1, 1'b1);
    check_now("start_req", 32'h1234, 32'h5678);

    // req arriving during RUN does not cancel the operation
    expect_res("req_in_run", 32'd0, 32'd6, 5);
    issue(4'd1, 32'd2, 32'd3, 1'b1, 1'b0);
    req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    drain();

    // mtlo while busy is ignored
    expect_res("mt_in_run", 32'd0, 32'h14, 5);
    issue(4'd1, 32'd4, 32'd5, 1'b1, 1'b0);
    mduOp = 4'd6; a = 32'hAAAA;
    @(posedge clk); #1 mduOp = 4'd0; a = 32'd0;
    drain();

    // reset during a divide clears state immediately
    expect_res("reset_mid_div", 32'd0, 32'd0, -1);
    issue(4'd3, 32'd100, 32'd3, 1'b1, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) @(posedge clk);
    check_now("no_late_write", 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
